// File: rtl/egress_frame_rx_if.sv
// Handshake bundle for egress_frame_rx: the marker-framed receive side plus the
// show-ahead egress stream. The slave modport is the receiver's view.
interface egress_frame_rx_if #(
  parameter int unsigned DATA_WIDTH = 64
);
  logic                  rd_sop;
  logic                  rd_vld;
  logic                  rd_eop;
  logic [DATA_WIDTH-1:0] rd_data;
  logic                  rx_ready;
  logic                  out_vld;
  logic                  out_rdy;
  logic [DATA_WIDTH-1:0] out_data;
  logic                  out_first;
  logic                  out_last;

  modport master (
    output rd_sop, rd_vld, rd_eop, rd_data, out_rdy,
    input  rx_ready, out_vld, out_data, out_first, out_last
  );

  modport slave (
    input  rd_sop, rd_vld, rd_eop, rd_data, out_rdy,
    output rx_ready, out_vld, out_data, out_first, out_last
  );
endinterface

// File: rtl/egress_frame_rx.sv
// Marker-framed packet receiver: validates header/payload framing, tags beats
// with first/last and buffers them in a show-ahead FIFO towards the egress port.
module egress_frame_rx #(
  parameter int unsigned DATA_WIDTH = 64,
  parameter int unsigned DEPTH      = 16,
  parameter int unsigned LEN_WIDTH  = 7
) (
  input  logic                 clk,
  input  logic                 rst,
  egress_frame_rx_if.slave     bus,
  output logic [3:0]           src_port,
  output logic [LEN_WIDTH-1:0] pkt_len,
  output logic [15:0]          pkt_cnt,
  output logic                 err_len,
  output logic                 err_frame,
  output logic                 err_ovf
);
  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;
  localparam int unsigned EW = DATA_WIDTH + 2;

  typedef enum logic [1:0] {IDLE, HDR, PAYLOAD, WAIT_EOP} state_t;

  state_t               state;
  logic [LEN_WIDTH-1:0] pay_cnt;
  logic                 excess;

  logic [EW-1:0]        mem [DEPTH];
  logic [AW-1:0]        wr_ptr;
  logic [AW-1:0]        rd_ptr;
  logic [CW-1:0]        count;
  logic [EW-1:0]        head;

  logic [LEN_WIDTH-1:0] hdr_len;
  logic [LEN_WIDTH-1:0] pay_next;
  logic                 act_sop, act_eop, act_vld;
  logic                 push_req, push_first, push_last, push_ok, pop;

  // Only the highest-priority marker of a cycle is acted on: sop > eop > vld.
  assign act_sop  = bus.rd_sop;
  assign act_eop  = !bus.rd_sop && bus.rd_eop;
  assign act_vld  = !bus.rd_sop && !bus.rd_eop && bus.rd_vld;

  assign hdr_len  = bus.rd_data[7 +: LEN_WIDTH];
  assign pay_next = pay_cnt + LEN_WIDTH'(1);

  always_comb begin
    push_req   = 1'b0;
    push_first = 1'b0;
    push_last  = 1'b0;
    if (act_vld) begin
      case (state)
        HDR: begin
          push_req   = 1'b1;
          push_first = 1'b1;
          push_last  = (hdr_len == '0);
        end
        PAYLOAD: begin
          push_req  = 1'b1;
          push_last = (pay_next == pkt_len);
        end
        default: ;
      endcase
    end
  end

  // A full FIFO still accepts a beat when the head leaves on the same edge.
  assign pop     = (count != '0) && bus.out_rdy;
  assign push_ok = push_req && ((count != CW'(DEPTH)) || pop);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + AW'(1);
      if (pop)     rd_ptr <= rd_ptr + AW'(1);
      case ({push_ok, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= {push_first, push_last, bus.rd_data};
  end

  assign head          = mem[rd_ptr];
  assign bus.out_vld   = (count != '0);
  assign bus.out_data  = bus.out_vld ? head[DATA_WIDTH-1:0] : '0;
  assign bus.out_first = bus.out_vld & head[EW-1];
  assign bus.out_last  = bus.out_vld & head[EW-2];
  assign bus.rx_ready  = (count <= CW'(DEPTH - 2));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      pay_cnt   <= '0;
      excess    <= 1'b0;
      src_port  <= '0;
      pkt_len   <= '0;
      pkt_cnt   <= '0;
      err_len   <= 1'b0;
      err_frame <= 1'b0;
      err_ovf   <= 1'b0;
    end else begin
      err_len   <= 1'b0;
      err_frame <= 1'b0;
      err_ovf   <= push_req && !push_ok;
      if (act_sop) begin
        // A new sop always restarts framing; mid-packet it abandons the old one.
        err_frame <= (state != IDLE);
        state     <= HDR;
        pay_cnt   <= '0;
        excess    <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            if (act_eop || act_vld) err_frame <= 1'b1;
          end
          HDR: begin
            if (act_eop) begin
              err_len <= 1'b1;
              state   <= IDLE;
            end else if (act_vld) begin
              src_port <= bus.rd_data[3:0];
              pkt_len  <= hdr_len;
              pay_cnt  <= '0;
              state    <= (hdr_len == '0) ? WAIT_EOP : PAYLOAD;
            end
          end
          PAYLOAD: begin
            if (act_eop) begin
              err_len <= 1'b1;
              state   <= IDLE;
            end else if (act_vld) begin
              pay_cnt <= pay_next;
              if (pay_next == pkt_len) state <= WAIT_EOP;
            end
          end
          WAIT_EOP: begin
            if (act_eop) begin
              if (excess) err_len <= 1'b1;
              else        pkt_cnt <= pkt_cnt + 16'd1;
              excess <= 1'b0;
              state  <= IDLE;
            end else if (act_vld) begin
              excess <= 1'b1;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end
endmodule
